// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared constants for the iterative square-root unit (states, widths, trial suffix).
package sqrt_pkg;
    localparam int RADICAND_W_DEF = 16;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] TRIAL_SUFFIX = 2'b01;
    function automatic int root_w_of(input int radicand_w);
        return radicand_w / 2;
    endfunction
endpackage

// File: rtl/sqrt_trial_sub.sv
// sqrt_trial_sub: combinational ripple-borrow subtractor, diff = a - b - borrow_in.
module sqrt_trial_sub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic [W-1:0] diff,
    output logic         borrow_out
);
    logic [W:0] bc;
    assign bc[0] = borrow_in;
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ bc[i];
        assign bc[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bc[i]);
    end
    assign borrow_out = bc[W];
endmodule

// File: rtl/sqrt_iter_ctrl.sv
// sqrt_iter_ctrl: restoring integer square root, 2 radicand bits per cycle, valid/ready on both sides.
// Define SQRT_REM_OUT_EN to add the rem_out port (radicand - root^2).
module sqrt_iter_ctrl
    import sqrt_pkg::*;
#(
    parameter int RADICAND_W = RADICAND_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RADICAND_W-1:0]   radicand,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RADICAND_W/2-1:0] root
`ifdef SQRT_REM_OUT_EN
    ,
    output logic [RADICAND_W/2:0]   rem_out
`endif
);
    localparam int ROOT_W = root_w_of(RADICAND_W);
    localparam int ITER   = RADICAND_W / 2;
    localparam int REM_W  = ROOT_W + 2;
    localparam int CNT_W  = $clog2(ITER);

    logic [1:0]            state;
    logic [RADICAND_W-1:0] rad_sh;
    logic [REM_W-1:0]      rem;
    logic [ROOT_W-1:0]     root_acc;
    logic [CNT_W-1:0]      cnt;
    logic [RADICAND_W-1:0] rem_sh, trial, diff;
    logic                  borrow, last;
    logic [REM_W-1:0]      rem_nxt;
    logic [ROOT_W-1:0]     root_nxt;
    logic                  unused_bits;

    // The true partial remainder never exceeds the bits consumed so far, so truncation is lossless.
    assign rem_sh = RADICAND_W'({rem, rad_sh[RADICAND_W-1 -: 2]});
    assign trial  = RADICAND_W'({root_acc, TRIAL_SUFFIX});

    sqrt_trial_sub #(.W(RADICAND_W)) u_sub (
        .a         (rem_sh),
        .b         (trial),
        .borrow_in (1'b0),
        .diff      (diff),
        .borrow_out(borrow)
    );

    assign rem_nxt     = borrow ? rem_sh[REM_W-1:0] : diff[REM_W-1:0];
    assign root_nxt    = {root_acc[ROOT_W-2:0], ~borrow};
    assign last        = cnt == CNT_W'(ITER - 1);
    assign in_ready    = state == IDLE;
    assign out_valid   = state == DONE;
    assign unused_bits = ^{diff, rem_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rad_sh   <= '0;
            rem      <= '0;
            root_acc <= '0;
            cnt      <= '0;
            root     <= '0;
`ifdef SQRT_REM_OUT_EN
            rem_out  <= '0;
`endif
        end else if (state == IDLE) begin
            if (in_valid) begin
                rad_sh   <= radicand;
                rem      <= '0;
                root_acc <= '0;
                cnt      <= '0;
                state    <= CALC;
            end
        end else if (state == CALC) begin
            rad_sh   <= rad_sh << 2;
            rem      <= rem_nxt;
            root_acc <= root_nxt;
            cnt      <= cnt + CNT_W'(1);
            if (last) begin
                state   <= DONE;
                root    <= root_nxt;
`ifdef SQRT_REM_OUT_EN
                rem_out <= rem_nxt[ROOT_W:0];
`endif
            end
        end else if (state == DONE) begin
            if (out_ready) state <= IDLE;
        end else begin
            state <= IDLE;
        end
    end
endmodule
